// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Brief    : Writeback requesters, register-file write port and issue-stage
//             scoreboard signals bundled for regfile_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              regwrite;
    logic [ADDR_W-1:0] regaddress;
    logic [DATA_W-1:0] writedata;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              hazard;
    logic [NREG-1:0]   pending;
    logic              wb_err;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  issue_valid, issue_dst, rs1, rs2,
        output a_ready, b_ready,
        output regwrite, regaddress, writedata,
        output hazard, pending, wb_err
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output issue_valid, issue_dst, rs1, rs2,
        input  a_ready, b_ready,
        input  regwrite, regaddress, writedata,
        input  hazard, pending, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Round-robin arbiter for the register-file write port with a
//             per-register pending scoreboard for RAW hazard detection.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    regfile_wb_arbiter_if.slave  bus
);

    logic              r_last_grant_b;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_regaddress;
    logic [DATA_W-1:0] r_writedata;
    logic [NREG-1:0]   r_pending;
    logic              r_wb_err;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_pending_nxt;

    // On a tie the requester that did not win last time gets the port.
    assign w_grant_a = ~reset & bus.a_valid & (~bus.b_valid |  r_last_grant_b);
    assign w_grant_b = ~reset & bus.b_valid & (~bus.a_valid | ~r_last_grant_b);
    assign w_accept  = w_grant_a | w_grant_b;
    assign w_addr    = w_grant_a ? bus.a_addr : bus.b_addr;
    assign w_data    = w_grant_a ? bus.a_data : bus.b_data;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (bus.issue_valid) begin
            w_set_mask = NREG'(1) << bus.issue_dst;
        end
        if (w_accept) begin
            w_clr_mask = NREG'(1) << w_addr;
        end
        // Set applied after clear so a newer producer keeps the bit.
        w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant_b <= 1'b1;
            r_regwrite     <= 1'b0;
            r_regaddress   <= '0;
            r_writedata    <= '0;
            r_pending      <= '0;
            r_wb_err       <= 1'b0;
        end else begin
            r_regwrite <= w_accept;
            r_pending  <= w_pending_nxt;
            if (w_accept) begin
                r_regaddress   <= w_addr;
                r_writedata    <= w_data;
                r_last_grant_b <= w_grant_b;
                if (!r_pending[w_addr]) begin
                    r_wb_err <= 1'b1;
                end
            end
        end
    end

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.regwrite   = r_regwrite;
    assign bus.regaddress = r_regaddress;
    assign bus.writedata  = r_writedata;
    assign bus.pending    = r_pending;
    assign bus.wb_err     = r_wb_err;
    assign bus.hazard     = r_pending[bus.rs1] | r_pending[bus.rs2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Brief    : Directed bench for regfile_wb_arbiter with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model state
    bit              m_pend [NREG];
    bit              m_last_b = 1'b1;
    logic            m_regwrite = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit              m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_a_ready();
        if (reset || !bus.a_valid) return 1'b0;
        if (!bus.b_valid) return 1'b1;
        return m_last_b;
    endfunction

    function automatic bit exp_b_ready();
        if (reset || !bus.b_valid) return 1'b0;
        if (!bus.a_valid) return 1'b1;
        return !m_last_b;
    endfunction

    function automatic logic [NREG-1:0] pend_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] win_addr();
        return exp_a_ready() ? bus.a_addr : bus.b_addr;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_regwrite <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
            m_err      <= 1'b0;
            m_last_b   <= 1'b1;
            for (int i = 0; i < NREG; i++) m_pend[i] <= 1'b0;
        end else begin
            m_regwrite <= exp_a_ready() | exp_b_ready();
            if (exp_a_ready()) begin
                m_addr   <= bus.a_addr;
                m_data   <= bus.a_data;
                m_last_b <= 1'b0;
            end else if (exp_b_ready()) begin
                m_addr   <= bus.b_addr;
                m_data   <= bus.b_data;
                m_last_b <= 1'b1;
            end
            if ((exp_a_ready() | exp_b_ready()) && !m_pend[win_addr()]) m_err <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                if (bus.issue_valid && bus.issue_dst == ADDR_W'(i))
                    m_pend[i] <= 1'b1;
                else if ((exp_a_ready() | exp_b_ready()) && win_addr() == ADDR_W'(i))
                    m_pend[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("m_a_ready",    32'(bus.a_ready),    32'(exp_a_ready()));
            check("m_b_ready",    32'(bus.b_ready),    32'(exp_b_ready()));
            check("m_regwrite",   32'(bus.regwrite),   32'(m_regwrite));
            check("m_regaddress", 32'(bus.regaddress), 32'(m_addr));
            check("m_writedata",  32'(bus.writedata),  32'(m_data));
            check("m_pending",    32'(bus.pending),    32'(pend_vec()));
            check("m_hazard",     32'(bus.hazard),     32'(m_pend[bus.rs1] | m_pend[bus.rs2]));
            check("m_wb_err",     32'(bus.wb_err),     32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b1; bus.b_addr = '0; bus.b_data = '0;
        bus.issue_valid = 1'b0; bus.issue_dst = '0;
        bus.rs1 = '0; bus.rs2 = '0;

        // Reset, with both requesters pushing
        tick(); #2;
        check("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("rst_b_ready", 32'(bus.b_ready), 32'd0);
        tick(); #2;
        check("rst_regwrite", 32'(bus.regwrite), 32'd0);
        check("rst_pending",  32'(bus.pending),  32'h0000);
        check("rst_wb_err",   32'(bus.wb_err),   32'd0);
        reset = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_dst = 4'd5;

        // Single write to r5
        tick();
        bus.issue_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 20'hABCDE;
        #2;
        check("sw_pending_before", 32'(bus.pending), 32'h0020);
        check("sw_a_ready",        32'(bus.a_ready), 32'd1);
        tick();
        bus.a_valid = 1'b0;
        #2;
        check("sw_regwrite",   32'(bus.regwrite),   32'd1);
        check("sw_regaddress", 32'(bus.regaddress), 32'd5);
        check("sw_writedata",  32'(bus.writedata),  32'hABCDE);
        check("sw_pending",    32'(bus.pending),    32'h0000);
        check("sw_wb_err",     32'(bus.wb_err),     32'd0);

        // A lone B write leaves B as last winner
        bus.issue_valid = 1'b1; bus.issue_dst = 4'd6;
        tick();
        bus.issue_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_addr = 4'd6; bus.b_data = 20'h66666;
        #2;
        check("b6_b_ready", 32'(bus.b_ready), 32'd1);
        tick();
        bus.b_valid = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(d);
            tick();
        end
        bus.issue_valid = 1'b0;

        // Contention: expected grants A,B,A,B
        bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 20'h11111;
        bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 20'h22222;
        #2;
        check("ct0_pending", 32'(bus.pending), 32'h001E);
        check("ct0_a_ready", 32'(bus.a_ready), 32'd1);
        check("ct0_b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_addr = 4'd3; bus.a_data = 20'h33333;
        #2;
        check("ct1_a_ready", 32'(bus.a_ready), 32'd0);
        check("ct1_b_ready", 32'(bus.b_ready), 32'd1);
        check("ct1_regaddress", 32'(bus.regaddress), 32'd1);
        tick();
        bus.b_addr = 4'd4; bus.b_data = 20'h44444;
        #2;
        check("ct2_a_ready", 32'(bus.a_ready), 32'd1);
        check("ct2_b_ready", 32'(bus.b_ready), 32'd0);
        check("ct2_regaddress", 32'(bus.regaddress), 32'd2);
        check("ct2_writedata",  32'(bus.writedata),  32'h22222);
        tick();
        bus.a_valid = 1'b0;
        #2;
        check("ct3_b_ready", 32'(bus.b_ready), 32'd1);
        check("ct3_regaddress", 32'(bus.regaddress), 32'd3);
        tick();
        bus.b_valid = 1'b0;
        #2;
        check("ct4_regaddress", 32'(bus.regaddress), 32'd4);
        check("ct4_writedata",  32'(bus.writedata),  32'h44444);
        check("ct4_pending",    32'(bus.pending),    32'h0000);

        // Hazard on rs1=7
        bus.issue_valid = 1'b1; bus.issue_dst = 4'd7;
        bus.rs1 = 4'd7; bus.rs2 = 4'd2;
        #2;
        check("hz_no_bypass", 32'(bus.hazard), 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_addr = 4'd7; bus.b_data = 20'h77777;
        #2;
        check("hz_set", 32'(bus.hazard), 32'd1);
        tick();
        bus.b_valid = 1'b0;
        #2;
        check("hz_clear", 32'(bus.hazard), 32'd0);
        check("hz_regaddress", 32'(bus.regaddress), 32'd7);

        // Same-cycle set/clear on r9, then split set/clear
        bus.issue_valid = 1'b1; bus.issue_dst = 4'd9; bus.rs1 = 4'd9;
        tick();
        bus.a_valid = 1'b1; bus.a_addr = 4'd9; bus.a_data = 20'h99999;
        #2;
        check("sc_a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        bus.a_data = 20'h09090; bus.issue_dst = 4'd15;
        #2;
        check("sc_pending9",   32'(bus.pending),    32'h0200);
        check("sc_regwrite",   32'(bus.regwrite),   32'd1);
        check("sc_regaddress", 32'(bus.regaddress), 32'd9);
        tick();
        bus.a_addr = 4'd15; bus.a_data = 20'hFFFFF; bus.issue_dst = 4'd0;
        #2;
        check("sc_pending15", 32'(bus.pending), 32'h8000);
        tick();
        bus.a_valid = 1'b0; bus.issue_valid = 1'b0;
        #2;
        check("sc_pending0",  32'(bus.pending),   32'h0001);
        check("sc_writedata", 32'(bus.writedata), 32'hFFFFF);
        tick(); #2;
        check("hold_regwrite",   32'(bus.regwrite),   32'd0);
        check("hold_regaddress", 32'(bus.regaddress), 32'd15);
        check("hold_writedata",  32'(bus.writedata),  32'hFFFFF);

        // Write to a non-pending register
        bus.a_valid = 1'b1; bus.a_addr = 4'd12; bus.a_data = 20'hCCCCC;
        tick();
        bus.a_valid = 1'b0;
        #2;
        check("err_wb_err",    32'(bus.wb_err),     32'd1);
        check("err_regwrite",  32'(bus.regwrite),   32'd1);
        check("err_regaddress",32'(bus.regaddress), 32'd12);
        check("err_writedata", 32'(bus.writedata),  32'hCCCCC);
        tick(); #2;
        check("err_sticky", 32'(bus.wb_err), 32'd1);

        // Reset while A is presenting a beat
        bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 20'h12345;
        bus.issue_valid = 1'b1; bus.issue_dst = 4'd8;
        reset = 1'b1;
        #2;
        check("mr_a_ready", 32'(bus.a_ready), 32'd0);
        tick();
        reset = 1'b0; bus.a_valid = 1'b0; bus.issue_valid = 1'b0;
        #2;
        check("mr_regwrite",   32'(bus.regwrite),   32'd0);
        check("mr_wb_err",     32'(bus.wb_err),     32'd0);
        check("mr_pending",    32'(bus.pending),    32'h0000);
        check("mr_regaddress", 32'(bus.regaddress), 32'd0);

        // After reset A wins the first tie
        bus.a_valid = 1'b1; bus.a_addr = 4'd1;
        bus.b_valid = 1'b1; bus.b_addr = 4'd2;
        #2;
        check("pr_a_ready", 32'(bus.a_ready), 32'd1);
        check("pr_b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
